// File: rtl/br_predictor.sv
// rtl/br_predictor.sv - direct-mapped BTB with 2-bit counters, EX-stage training and mispredict redirect
module br_predictor #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_fetch_pc,
  output logic             o_pred_taken,
  output logic [31:0]      o_pred_pc,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_br,
  input  logic [31:0]      i_ex_pc,
  input  logic [31:0]      i_ex_target,
  input  logic             i_ex_taken,
  input  logic             i_ex_pred_taken,
  input  logic [31:0]      i_ex_pred_pc,
  output logic             o_mispred,
  output logic [31:0]      o_redirect_pc,
  output logic [CNT_W-1:0] o_mispred_cnt
);
  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit, upd;
  logic             unused;

  assign f_idx = i_fetch_pc[IDX_W+1:2];
  assign f_tag = i_fetch_pc[31:IDX_W+2];
  assign e_idx = i_ex_pc[IDX_W+1:2];
  assign e_tag = i_ex_pc[31:IDX_W+2];

  // The piped-down direction bit is redundant: comparing full next-PCs covers it.
  assign unused = ^{i_fetch_pc[1:0], i_ex_pc[1:0], i_ex_pred_taken};

  assign f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign o_pred_taken = f_hit && ctr_q[f_idx][1];
  assign o_pred_pc    = o_pred_taken ? target_q[f_idx] : i_fetch_pc + 32'd4;

  assign upd           = i_ex_valid && i_ex_is_br;
  assign e_hit         = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign o_redirect_pc = (upd && i_ex_taken) ? i_ex_target : i_ex_pc + 32'd4;
  assign o_mispred     = upd && (i_ex_pred_pc != o_redirect_pc);
  assign o_mispred_cnt = cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd) begin
      if (e_hit) begin
        if (i_ex_taken) begin
          ctr_q[e_idx]    <= (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'd1;
          target_q[e_idx] <= i_ex_target;
        end else begin
          ctr_q[e_idx] <= (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'd1;
        end
      end else if (i_ex_taken) begin
        // Fresh entries start weakly taken; not-taken misses never allocate.
        valid_q[e_idx]  <= 1'b1;
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= i_ex_target;
        ctr_q[e_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (o_mispred && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_br_predictor.sv
// tb/tb_br_predictor.sv - randomized and directed checks of br_predictor against a table model
module tb_br_predictor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        ex_valid = 1'b0, ex_is_br = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_pc = '0;
  logic        pred_taken, mispred, pred_taken2, mispred2;
  logic [31:0] pred_pc, redirect_pc, pred_pc2, redirect_pc2;
  logic [15:0] mispred_cnt;
  logic [1:0]  mispred_cnt2;

  int checks = 0;
  int errors = 0;

  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_cnt;

  always #5 clk = ~clk;

  br_predictor #(.IDX_W(4), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fetch_pc(fetch_pc),
    .o_pred_taken(pred_taken), .o_pred_pc(pred_pc),
    .i_ex_valid(ex_valid), .i_ex_is_br(ex_is_br), .i_ex_pc(ex_pc),
    .i_ex_target(ex_target), .i_ex_taken(ex_taken),
    .i_ex_pred_taken(ex_pred_taken), .i_ex_pred_pc(ex_pred_pc),
    .o_mispred(mispred), .o_redirect_pc(redirect_pc), .o_mispred_cnt(mispred_cnt)
  );

  br_predictor #(.IDX_W(4), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_fetch_pc(fetch_pc),
    .o_pred_taken(pred_taken2), .o_pred_pc(pred_pc2),
    .i_ex_valid(ex_valid), .i_ex_is_br(ex_is_br), .i_ex_pc(ex_pc),
    .i_ex_target(ex_target), .i_ex_taken(ex_taken),
    .i_ex_pred_taken(ex_pred_taken), .i_ex_pred_pc(ex_pred_pc),
    .o_mispred(mispred2), .o_redirect_pc(redirect_pc2), .o_mispred_cnt(mispred_cnt2)
  );

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    int i = m_idx(pc);
    return m_valid[i] && (m_tag[i] == 26'(pc >> 6)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_ppc(input logic [31:0] pc);
    return m_pred(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_redirect();
    return (ex_valid && ex_is_br && ex_taken) ? ex_target : ex_pc + 32'd4;
  endfunction

  function automatic bit m_mispred();
    return ex_valid && ex_is_br && (ex_pred_pc != m_redirect());
  endfunction

  function automatic logic [15:0] m_cnt16();
    return (m_cnt > 65535) ? 16'hffff : 16'(m_cnt);
  endfunction

  function automatic logic [1:0] m_cnt2();
    return (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_cnt = 0;
  endtask

  task automatic m_train();
    int i = m_idx(ex_pc);
    bit hit = m_valid[i] && (m_tag[i] == 26'(ex_pc >> 6));
    if (!(ex_valid && ex_is_br)) return;
    if (hit && ex_taken) begin
      m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
      m_tgt[i] = ex_target;
    end else if (hit) begin
      m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
    end else if (ex_taken) begin
      m_valid[i] = 1'b1; m_tag[i] = 26'(ex_pc >> 6); m_tgt[i] = ex_target; m_ctr[i] = 2;
    end
  endtask

  task automatic drive(input logic [31:0] f, input bit v, input bit br, input logic [31:0] epc,
                       input logic [31:0] tgt, input bit tk, input logic [31:0] ppc);
    fetch_pc = f; ex_valid = v; ex_is_br = br; ex_pc = epc;
    ex_target = tgt; ex_taken = tk; ex_pred_pc = ppc; ex_pred_taken = (ppc != epc + 32'd4);
    #1;
  endtask

  task automatic tick();
    bit mp = m_mispred();
    @(posedge clk);
    if (mp) m_cnt++;
    m_train();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h4);
    rst_n = 1'b0;
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_clear();
    drive(32'h0000_0100, 0, 0, 32'h0000_0300, 32'h40, 1, 32'h40);
    checks++; if (mispred_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", mispred_cnt); end
    checks++; if (mispred_cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt2 got %0d exp 0", mispred_cnt2); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %b exp 0", pred_taken); end
    checks++; if (pred_pc !== 32'h104) begin errors++; $display("FAIL reset_pred_pc got %h exp 104", pred_pc); end
    checks++; if (mispred !== 1'b0) begin errors++; $display("FAIL reset_idle_mispred got %b exp 0", mispred); end
    checks++; if (redirect_pc !== 32'h304) begin errors++; $display("FAIL reset_idle_redirect got %h exp 304", redirect_pc); end
    drive(32'h0000_0ab0, 1, 0, 32'h0000_0500, 32'h40, 1, 32'h40);
    checks++; if (mispred !== 1'b0) begin errors++; $display("FAIL reset_nonbr_mispred got %b exp 0", mispred); end
    checks++; if (redirect_pc !== 32'h504) begin errors++; $display("FAIL reset_nonbr_redirect got %h exp 504", redirect_pc); end
    checks++; if (pred_pc !== 32'hab4) begin errors++; $display("FAIL reset_pred_pc2 got %h exp ab4", pred_pc); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cold_start();
    do_reset();
    drive(32'h100, 1, 1, 32'h100, 32'h80, 1, 32'h104);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL cold_pred_taken got %b exp 0", pred_taken); end
    checks++; if (pred_pc !== 32'h104) begin errors++; $display("FAIL cold_pred_pc got %h exp 104", pred_pc); end
    checks++; if (mispred !== 1'b1) begin errors++; $display("FAIL cold_mispred got %b exp 1", mispred); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL cold_redirect got %h exp 80", redirect_pc); end
    tick();
    drive(32'h100, 0, 0, 32'h0, 32'h0, 0, 32'h4);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL cold_after_taken got %b exp 1", pred_taken); end
    checks++; if (pred_pc !== 32'h80) begin errors++; $display("FAIL cold_after_pc got %h exp 80", pred_pc); end
    checks++; if (mispred_cnt !== 16'd1) begin errors++; $display("FAIL cold_cnt got %0d exp 1", mispred_cnt); end
  endtask

  task automatic test_hysteresis();
    bit exp_tk [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bit res_tk [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      drive(32'h100, 1, 1, 32'h100, 32'h80, res_tk[k], m_ppc(32'h100));
      tick();
      drive(32'h100, 0, 0, 32'h0, 32'h0, 0, 32'h4);
      checks++;
      if (pred_taken !== exp_tk[k] || pred_taken !== m_pred(32'h100)) begin
        errors++; $display("FAIL hyst_step%0d pred_taken got %b exp %b", k, pred_taken, exp_tk[k]);
      end
    end
    checks++; if (pred_pc !== 32'h80) begin errors++; $display("FAIL hyst_pred_pc got %h exp 80", pred_pc); end
    checks++; if (mispred_cnt !== m_cnt16()) begin errors++; $display("FAIL hyst_cnt got %0d exp %0d", mispred_cnt, m_cnt16()); end
  endtask

  task automatic test_not_taken_miss();
    drive(32'h200, 1, 1, 32'h200, 32'h300, 0, 32'h204);
    checks++; if (mispred !== 1'b0) begin errors++; $display("FAIL ntmiss_mispred got %b exp 0", mispred); end
    checks++; if (redirect_pc !== 32'h204) begin errors++; $display("FAIL ntmiss_redirect got %h exp 204", redirect_pc); end
    tick();
    drive(32'h200, 0, 0, 32'h0, 32'h0, 0, 32'h4);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ntmiss_alloc got %b exp 0", pred_taken); end
    checks++; if (pred_pc !== 32'h204) begin errors++; $display("FAIL ntmiss_pred_pc got %h exp 204", pred_pc); end
  endtask

  task automatic test_target_change();
    drive(32'h100, 1, 1, 32'h100, 32'h80, 1, 32'h80);
    tick();
    drive(32'h100, 1, 1, 32'h100, 32'h90, 1, 32'h80);
    checks++; if (mispred !== 1'b1) begin errors++; $display("FAIL tgt_mispred got %b exp 1", mispred); end
    checks++; if (redirect_pc !== 32'h90) begin errors++; $display("FAIL tgt_redirect got %h exp 90", redirect_pc); end
    tick();
    drive(32'h100, 0, 0, 32'h0, 32'h0, 0, 32'h4);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL tgt_pred_taken got %b exp 1", pred_taken); end
    checks++; if (pred_pc !== 32'h90) begin errors++; $display("FAIL tgt_pred_pc got %h exp 90", pred_pc); end
  endtask

  task automatic test_alias_collision();
    drive(32'h140, 1, 1, 32'h140, 32'h400, 1, 32'h144);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL coll_same_cycle got %b exp 0", pred_taken); end
    checks++; if (pred_pc !== 32'h144) begin errors++; $display("FAIL coll_same_cycle_pc got %h exp 144", pred_pc); end
    tick();
    drive(32'h140, 0, 0, 32'h0, 32'h0, 0, 32'h4);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL coll_next_cycle got %b exp 1", pred_taken); end
    checks++; if (pred_pc !== 32'h400) begin errors++; $display("FAIL coll_next_pc got %h exp 400", pred_pc); end
    drive(32'h100, 0, 0, 32'h0, 32'h0, 0, 32'h4);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evict got %b exp 0", pred_taken); end
    checks++; if (pred_pc !== 32'h104) begin errors++; $display("FAIL alias_evict_pc got %h exp 104", pred_pc); end
  endtask

  task automatic test_async_reset();
    logic [31:0] pcs [3] = '{32'h100, 32'h200, 32'h300};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(32'h0, 1, 1, pcs[k], pcs[k] + 32'h800, 1, pcs[k] + 32'd4);
      tick();
    end
    checks++; if (mispred_cnt !== 16'd3) begin errors++; $display("FAIL arst_pre_cnt got %0d exp 3", mispred_cnt); end
    drive(32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h4);
    @(posedge clk);
    #1 rst_n = 1'b0;
    m_clear();
    #0.5;
    checks++; if (mispred_cnt !== 16'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", mispred_cnt); end
    for (int k = 0; k < 3; k++) begin
      fetch_pc = pcs[k];
      #0.5;
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL arst_lookup_%h got %b exp 0", pcs[k], pred_taken); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    drive(32'h100, 1, 1, 32'h100, 32'h700, 1, 32'h104);
    tick();
    drive(32'h100, 0, 0, 32'h0, 32'h0, 0, 32'h4);
    checks++; if (pred_pc !== 32'h700) begin errors++; $display("FAIL arst_retrain got %h exp 700", pred_pc); end
    checks++; if (mispred_cnt !== 16'd1) begin errors++; $display("FAIL arst_retrain_cnt got %0d exp 1", mispred_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(32'h0, 1, 1, 32'h300, 32'h0, 0, 32'h0);
      tick();
    end
    checks++; if (mispred_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got %0d exp 3", mispred_cnt2); end
    checks++; if (mispred_cnt !== 16'd5) begin errors++; $display("FAIL sat_cnt16 got %0d exp 5", mispred_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] f, epc, tgt, ppc;
    int sel;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      f   = 32'h1000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 6);
      epc = 32'h1000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 6);
      tgt = 32'h2000 | (32'($urandom_range(0, 3)) << 4);
      sel = $urandom_range(0, 3);
      ppc = (sel == 0) ? epc + 32'd4 : (sel == 1) ? tgt : m_ppc(epc);
      drive(f, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, epc, tgt, $urandom_range(0, 2) != 0, ppc);
      checks++;
      if (pred_taken !== m_pred(f) || pred_pc !== m_ppc(f)) begin
        errors++; $display("FAIL rnd_lookup pc %h got %b/%h exp %b/%h", f, pred_taken, pred_pc, m_pred(f), m_ppc(f));
      end
      checks++;
      if (mispred !== m_mispred() || redirect_pc !== m_redirect()) begin
        errors++; $display("FAIL rnd_resolve got %b/%h exp %b/%h", mispred, redirect_pc, m_mispred(), m_redirect());
      end
      tick();
      checks++;
      if (mispred_cnt !== m_cnt16() || mispred_cnt2 !== m_cnt2()) begin
        errors++; $display("FAIL rnd_cnt got %0d/%0d exp %0d/%0d", mispred_cnt, mispred_cnt2, m_cnt16(), m_cnt2());
      end
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_cold_start();
    test_hysteresis();
    test_not_taken_miss();
    test_target_change();
    test_alias_collision();
    test_async_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_predictor.md
Name: br_predictor

Overview:
- Fetch-stage dynamic branch predictor: a direct-mapped BTB plus 2-bit saturating counters.
- Sits at the other end of the branch comparator. It predicts taken/target at IF and consumes the EX-stage resolution (comparator pc_sel) to train itself.
- Flags mispredictions and supplies the corrected PC to the PC mux and the pipeline flush logic.

Parameters:
- IDX_W, 4, index bits; table holds 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- CNT_W, 16, width of the saturating mispredict statistics counter.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_fetch_pc  in  32  PC being fetched.
- o_pred_taken  out  1  prediction for i_fetch_pc: taken.
- o_pred_pc  out  32  predicted next PC.
- i_ex_valid  in  1  EX stage holds a valid, non-flushed instruction.
- i_ex_is_br  in  1  EX instruction is a conditional branch.
- i_ex_pc  in  32  PC of the EX instruction.
- i_ex_target  in  32  computed branch target (pc + imm).
- i_ex_taken  in  1  branch outcome from the comparator (pc_sel).
- i_ex_pred_taken  in  1  prediction made for this instruction at IF, piped down.
- i_ex_pred_pc  in  32  predicted next PC made at IF, piped down.
- o_mispred  out  1  misprediction; flush IF/ID and redirect.
- o_redirect_pc  out  32  correct next PC.
- o_mispred_cnt  out  CNT_W  saturating count of mispredictions.

Behaviour:
- Entry fields: valid (1), tag = pc[31:IDX_W+2], target (32), ctr (2).
- Reset (async, i_rst_n=0):
  - All valid bits = 0 and all ctr = 2'b01.
  - o_mispred_cnt = 0.
  - Lookup outputs then read o_pred_taken = 0, o_pred_pc = i_fetch_pc + 4.
  - o_mispred depends only on EX inputs.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx] == fetch tag.
  - o_pred_taken = hit && ctr[idx][1].
  - o_pred_pc = o_pred_taken ? target[idx] : i_fetch_pc + 4.
- Resolution (combinational), with upd = i_ex_valid && i_ex_is_br:
  - o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc + 4.
  - o_mispred = upd && (i_ex_pred_pc != o_redirect_pc). This covers both direction and target errors.
  - When upd = 0: o_mispred = 0 and o_redirect_pc = i_ex_pc + 4.
- Training (rising edge, when upd = 1; EX index/tag taken from i_ex_pc):
  - EX hit, taken: ctr = sat_inc(ctr), saturating at 2'b11; target = i_ex_target.
  - EX hit, not taken: ctr = sat_dec(ctr), saturating at 2'b00; target unchanged.
  - EX miss, taken: allocate or overwrite the entry: valid = 1, tag, target = i_ex_target, ctr = 2'b10.
  - EX miss, not taken: no change (no allocation).
  - When upd = 0: table is unchanged.
- Statistics: o_mispred_cnt increments on each rising edge where o_mispred = 1. It holds at all-ones; there is no wrap.
- Same-cycle collision: fetch lookup and EX training on the same index read the pre-update contents. The new value is visible the next cycle; there is no bypass.
- Aliasing: different PCs with the same index and a different tag evict each other. Same index and same tag alias silently; this is accepted.
- Reset asserted mid-operation: table and counter clear immediately, with no clock required. The first edge after deassertion trains normally.
- Table is flop-based: no SRAM and no read latency.

Test Plan:
- Cold start: reset, then fetch_pc = 0x100 -> pred_taken = 0, pred_pc = 0x104. EX branch at 0x100, taken, target = 0x80, pred_pc = 0x104 -> mispred = 1, redirect = 0x80. Next cycle, fetch 0x100 -> pred_taken = 1, pred_pc = 0x80; mispred_cnt = 1.
- Hysteresis: after allocation (ctr = 10), one not-taken resolution at 0x100 -> ctr = 01, pred_taken = 0. Two taken resolutions -> ctr = 11. One not-taken -> ctr = 10, pred_taken still 1.
- Not-taken miss: EX branch at 0x200, not taken, pred_pc = 0x204 -> mispred = 0, redirect = 0x204, no allocation. Fetch 0x200 -> pred_taken = 0.
- Target change: entry 0x100 -> 0x80 with ctr = 11. EX taken with target 0x90 and pred_pc = 0x80 -> mispred = 1, redirect = 0x90. Next fetch 0x100 -> pred_pc = 0x90.
- Alias and collision (IDX_W = 4): allocate 0x100 and then 0x140 (same index) -> fetch 0x100 misses. Same-cycle fetch 0x140 during its own allocation -> old miss result, hit on the next cycle.
- Async reset mid-run: table populated, mispred_cnt = 3. Pulse i_rst_n low between clock edges -> cnt = 0 immediately and all lookups miss. Saturation check with CNT_W = 2: 5 mispredicts -> cnt = 3.
